// File: rtl/axi_rd_line_collector_if.sv
// Bundle of the three handshake groups around the read line collector.
//   req_*  : cache read request into the collector (valid/ready).
//   rd_*   : AR-style request to the AXI shim (rd_req_o/rd_gnt_i) and the
//            beat-by-beat read response sink (rd_valid_i/rd_rdy_o).
//   line_* : assembled line back to the cache (valid/ready).
// Handshake rule: a transfer happens on a rising clock edge where the
// producer's valid (or rd_req_o) and the consumer's ready (or rd_gnt_i) are
// both high; a producer holds valid and payload stable until that edge.
// Modport slave is the collector's view; modport master is the environment.
interface axi_rd_line_collector_if #(
    parameter int AxiNumWords = 4,
    parameter int AxiIdWidth  = 4
);
    localparam int CntW = $clog2(AxiNumWords) + 1;
    localparam int BlW  = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1;

    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [63:0]               req_addr_i;
    logic [BlW-1:0]            req_blen_i;
    logic [1:0]                req_size_i;
    logic [AxiIdWidth-1:0]     req_id_i;

    logic                      rd_req_o;
    logic                      rd_gnt_i;
    logic [63:0]               rd_addr_o;
    logic [BlW-1:0]            rd_blen_o;
    logic [1:0]                rd_size_o;
    logic [AxiIdWidth-1:0]     rd_id_o;
    logic                      rd_rdy_o;
    logic                      rd_valid_i;
    logic                      rd_last_i;
    logic [63:0]               rd_data_i;
    logic [AxiIdWidth-1:0]     rd_rid_i;
    logic                      rd_exokay_i;

    logic                      line_valid_o;
    logic                      line_ready_i;
    logic [64*AxiNumWords-1:0] line_data_o;
    logic [AxiIdWidth-1:0]     line_id_o;
    logic [CntW-1:0]           line_beats_o;
    logic                      line_exokay_o;
    logic                      line_err_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_blen_i, req_size_i, req_id_i,
        output req_ready_o,
        output rd_req_o, rd_addr_o, rd_blen_o, rd_size_o, rd_id_o, rd_rdy_o,
        input  rd_gnt_i, rd_valid_i, rd_last_i, rd_data_i, rd_rid_i, rd_exokay_i,
        output line_valid_o, line_data_o, line_id_o, line_beats_o,
        output line_exokay_o, line_err_o,
        input  line_ready_i
    );

    modport master (
        output req_valid_i, req_addr_i, req_blen_i, req_size_i, req_id_i,
        input  req_ready_o,
        input  rd_req_o, rd_addr_o, rd_blen_o, rd_size_o, rd_id_o, rd_rdy_o,
        output rd_gnt_i, rd_valid_i, rd_last_i, rd_data_i, rd_rid_i, rd_exokay_i,
        input  line_valid_o, line_data_o, line_id_o, line_beats_o,
        input  line_exokay_o, line_err_o,
        output line_ready_i
    );
endinterface

// File: rtl/axi_rd_line_collector.sv
// Read line collector: takes one cache read request, issues it to the AXI
// shim, gathers the response beats into a line buffer and hands the full
// line back with aggregated EXOKAY and protocol-error status. One
// transaction in flight at a time.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   bus          axi_rd_line_collector_if.slave (req_*, rd_*, line_* groups)
//   dbg_state_o  current FSM state (IDLE=0, ADDR=1, DATA=2, OUT=3)
module axi_rd_line_collector #(
    parameter int AxiNumWords = 4,
    parameter int AxiIdWidth  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    axi_rd_line_collector_if.slave      bus,
    output logic [1:0]                  dbg_state_o
);
    localparam int CntW = $clog2(AxiNumWords) + 1;
    localparam int BlW  = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        OUT  = 2'd3
    } state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [63:0]           addr_q;
    logic [BlW-1:0]        blen_q;
    logic [1:0]            size_q;
    logic [AxiIdWidth-1:0] id_q;
    logic                  err_q;
    logic                  exokay_q;
    logic [63:0]           line_q [AxiNumWords];

    logic [CntW-1:0]       blen_ext;
    logic                  id_match;
    logic                  store_ok;

    assign blen_ext = CntW'(blen_q);
    assign id_match = (bus.rd_rid_i == id_q);
    // The second term keeps the write index inside the buffer even when a
    // non-power-of-two line size lets blen encode more words than exist.
    assign store_ok = (cnt_q <= blen_ext) && (cnt_q < CntW'(AxiNumWords));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            blen_q   <= '0;
            size_q   <= '0;
            id_q     <= '0;
            err_q    <= 1'b0;
            exokay_q <= 1'b1;
            for (int k = 0; k < AxiNumWords; k++) line_q[k] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        addr_q   <= bus.req_addr_i;
                        blen_q   <= bus.req_blen_i;
                        size_q   <= bus.req_size_i;
                        id_q     <= bus.req_id_i;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                        exokay_q <= 1'b1;
                        for (int k = 0; k < AxiNumWords; k++) line_q[k] <= '0;
                        state_q  <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.rd_gnt_i) state_q <= DATA;
                end
                DATA: begin
                    if (bus.rd_valid_i) begin
                        if (!id_match) begin
                            // Foreign beat: dropped entirely, its last flag too.
                            err_q <= 1'b1;
                        end else begin
                            if (store_ok) begin
                                line_q[cnt_q[BlW-1:0]] <= bus.rd_data_i;
                                cnt_q    <= cnt_q + CntW'(1);
                                exokay_q <= exokay_q & bus.rd_exokay_i;
                            end else begin
                                // Overrun: more beats than requested, counter holds.
                                err_q <= 1'b1;
                            end
                            if (bus.rd_last_i) begin
                                state_q <= OUT;
                                if (cnt_q != blen_ext) err_q <= 1'b1;
                            end
                        end
                    end
                end
                OUT: begin
                    if (bus.line_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from state and registers only, and forced low
    // while reset is held so nothing leaks out during the reset cycle.
    assign dbg_state_o       = rst_ni ? state_q : 2'd0;
    assign bus.req_ready_o   = rst_ni && (state_q == IDLE);
    assign bus.rd_req_o      = rst_ni && (state_q == ADDR);
    assign bus.rd_rdy_o      = rst_ni && (state_q == DATA);
    assign bus.rd_addr_o     = rst_ni ? addr_q : '0;
    assign bus.rd_blen_o     = rst_ni ? blen_q : '0;
    assign bus.rd_size_o     = rst_ni ? size_q : '0;
    assign bus.rd_id_o       = rst_ni ? id_q : '0;
    assign bus.line_valid_o  = rst_ni && (state_q == OUT);
    assign bus.line_id_o     = rst_ni ? id_q : '0;
    assign bus.line_beats_o  = rst_ni ? cnt_q : '0;
    assign bus.line_exokay_o = rst_ni && exokay_q && (cnt_q != '0);
    assign bus.line_err_o    = rst_ni && err_q;

    always_comb begin
        bus.line_data_o = '0;
        if (rst_ni) begin
            for (int k = 0; k < AxiNumWords; k++) bus.line_data_o[64*k +: 64] = line_q[k];
        end
    end
endmodule
